// File: rtl/game_pkg.sv
// game_pkg: one-hot game state encoding and playfield geometry shared by the
// sequencer, bird physics and the renderer.
package game_pkg;
    localparam logic [3:0] START_SCREEN = 4'b0001;
    localparam logic [3:0] IN_GAME      = 4'b0010;
    localparam logic [3:0] PAUSE        = 4'b0100;
    localparam logic [3:0] END_SCREEN   = 4'b1000;
    localparam int SCREEN_H    = 480;
    localparam int BIRD_SIZE_Y = 20;
endpackage

// File: rtl/btn_edge_sync.sv
// btn_edge_sync: brings a raw button into the clock domain and emits a
// single-tick pulse on each press.
module btn_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);
    logic [1:0] sync;
    logic       prev;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            prev <= sync[1];
        end
    end
    assign pulse = sync[1] & ~prev;
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: round sequencer for the flappy-bird datapath; owns the
// one-hot game state, score, high score and the flap/round-reset pulses.
module game_flow_ctrl #(
    parameter int BIRD_SIZE_Y = game_pkg::BIRD_SIZE_Y,
    parameter int SCREEN_H    = game_pkg::SCREEN_H,
    parameter int END_HOLD    = 60,
    parameter int SCORE_MAX   = 999
) (
    input  logic        GAME_clk,
    input  logic        rst,
    input  logic        btn_flap,
    input  logic        btn_pause,
    input  logic        collision,
    input  logic        pipe_passed,
    input  logic [15:0] birdY,
    output logic [3:0]  game_state,
    output logic        flap,
    output logic        round_rst,
    output logic [9:0]  score,
    output logic [9:0]  high_score
);
    import game_pkg::*;
    localparam int HW = $clog2(END_HOLD + 1);
    localparam logic [15:0] FLOOR = 16'(SCREEN_H - BIRD_SIZE_Y);
    logic          f_edge, p_edge, oob;
    logic [HW-1:0] hold;
    btn_edge_sync u_flap  (.clk(GAME_clk), .rst(rst), .btn(btn_flap),  .pulse(f_edge));
    btn_edge_sync u_pause (.clk(GAME_clk), .rst(rst), .btn(btn_pause), .pulse(p_edge));
    // Bit 15 set means physics wrapped above the ceiling.
    assign oob = (birdY >= FLOOR) || birdY[15];
    always_ff @(posedge GAME_clk or posedge rst) begin
        if (rst) begin
            game_state <= START_SCREEN;
            flap       <= 1'b0;
            round_rst  <= 1'b0;
            score      <= '0;
            high_score <= '0;
            hold       <= '0;
        end else begin
            flap      <= 1'b0;
            round_rst <= 1'b0;
            case (game_state)
                START_SCREEN: if (f_edge) begin
                    game_state <= IN_GAME;
                    flap       <= 1'b1;
                    score      <= '0;
                end
                IN_GAME: if (collision || oob) begin
                    game_state <= END_SCREEN;
                    high_score <= (score > high_score) ? score : high_score;
                    hold       <= '0;
                end else begin
                    if (p_edge) game_state <= PAUSE;
                    else flap <= f_edge;
                    if (pipe_passed && score != 10'(SCORE_MAX)) score <= score + 10'd1;
                end
                PAUSE: if (p_edge) game_state <= IN_GAME;
                END_SCREEN: begin
                    if (hold != HW'(END_HOLD)) hold <= hold + 1'b1;
                    if (f_edge && hold == HW'(END_HOLD)) begin
                        game_state <= START_SCREEN;
                        round_rst  <= 1'b1;
                    end
                end
                default: game_state <= START_SCREEN;
            endcase
        end
    end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed and random stimulus against a tick-level game
// model; expectations are queued at stimulus time and checked by a monitor.
module tb_game_flow_ctrl;
    logic        GAME_clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_flap = 1'b0, btn_pause = 1'b0, collision = 1'b0, pipe_passed = 1'b0;
    logic [15:0] birdY = 16'd200;
    logic [3:0]  game_state;
    logic        flap, round_rst;
    logic [9:0]  score, high_score;

    game_flow_ctrl dut (
        .GAME_clk(GAME_clk), .rst(rst), .btn_flap(btn_flap), .btn_pause(btn_pause),
        .collision(collision), .pipe_passed(pipe_passed), .birdY(birdY),
        .game_state(game_state), .flap(flap), .round_rst(round_rst),
        .score(score), .high_score(high_score)
    );

    always #5 GAME_clk = ~GAME_clk;

    typedef enum int {M_START = 0, M_GAME = 1, M_PAUSE = 2, M_END = 3} mode_t;
    typedef struct packed {
        logic [3:0] st;
        logic       fl;
        logic       rr;
        logic [9:0] sc;
        logic [9:0] hi;
    } exp_t;

    exp_t  sb[$];
    int    n_vec = 0, n_bad = 0;
    mode_t mode;
    int    m_score, m_high, m_end_ticks;
    logic  fq[$], pq[$];

    task automatic model_init();
        mode = M_START;
        m_score = 0;
        m_high = 0;
        m_end_ticks = 0;
        fq = '{1'b0, 1'b0, 1'b0, 1'b0};
        pq = '{1'b0, 1'b0, 1'b0, 1'b0};
    endtask

    // A press is seen by the game two samples after it is captured, once only.
    task automatic model_step(input logic bf, bp, col, pp, input logic [15:0] by);
        logic fe, pe, oob, e_fl, e_rr;
        exp_t e;
        fe = fq[1] & ~fq[2];
        pe = pq[1] & ~pq[2];
        fq.push_front(bf); void'(fq.pop_back());
        pq.push_front(bp); void'(pq.pop_back());
        oob = (int'(by) >= 460) || (int'(by) >= 32768);
        e_fl = 1'b0;
        e_rr = 1'b0;
        case (mode)
            M_START: if (fe) begin mode = M_GAME; e_fl = 1'b1; m_score = 0; end
            M_GAME: if (col || oob) begin
                mode = M_END;
                if (m_score > m_high) m_high = m_score;
                m_end_ticks = 0;
            end else begin
                if (pe) mode = M_PAUSE;
                else e_fl = fe;
                if (pp && m_score < 999) m_score++;
            end
            M_PAUSE: if (pe) mode = M_GAME;
            M_END: begin
                if (fe && m_end_ticks >= 60) begin mode = M_START; e_rr = 1'b1; end
                if (m_end_ticks < 60) m_end_ticks++;
            end
            default: mode = M_START;
        endcase
        e.st = 4'(1 << int'(mode));
        e.fl = e_fl;
        e.rr = e_rr;
        e.sc = 10'(m_score);
        e.hi = 10'(m_high);
        sb.push_back(e);
    endtask

    always @(posedge GAME_clk) begin
        exp_t e;
        logic bad;
        #1;
        if (!rst && sb.size() > 0) begin
            e = sb.pop_front();
            bad = 1'b0;
            n_vec++;
            if (game_state !== e.st) begin $display("FAIL game_state got %b exp %b t=%0t", game_state, e.st, $time); bad = 1'b1; end
            if (flap !== e.fl) begin $display("FAIL flap got %b exp %b t=%0t", flap, e.fl, $time); bad = 1'b1; end
            if (round_rst !== e.rr) begin $display("FAIL round_rst got %b exp %b t=%0t", round_rst, e.rr, $time); bad = 1'b1; end
            if (score !== e.sc) begin $display("FAIL score got %0d exp %0d t=%0t", score, e.sc, $time); bad = 1'b1; end
            if (high_score !== e.hi) begin $display("FAIL high_score got %0d exp %0d t=%0t", high_score, e.hi, $time); bad = 1'b1; end
            if (bad) n_bad++;
        end
    end

    task automatic check_reset(input string name);
        n_vec++;
        if (game_state !== 4'b0001 || flap !== 1'b0 || round_rst !== 1'b0 || score !== 10'd0 || high_score !== 10'd0) begin
            n_bad++;
            $display("FAIL %s got st=%b fl=%b rr=%b sc=%0d hi=%0d exp st=0001 fl=0 rr=0 sc=0 hi=0",
                     name, game_state, flap, round_rst, score, high_score);
        end
    endtask

    task automatic drive(input logic bf, bp, col, pp, input logic [15:0] by);
        btn_flap = bf; btn_pause = bp; collision = col; pipe_passed = pp; birdY = by;
    endtask

    task automatic tick(input logic bf, bp, col, pp, input logic [15:0] by);
        @(negedge GAME_clk);
        drive(bf, bp, col, pp, by);
        model_step(bf, bp, col, pp, by);
    endtask

    task automatic do_reset();
        @(negedge GAME_clk);
        drive(0, 0, 0, 0, 16'd200);
        rst = 1'b1;
        sb.delete();
        model_init();
        repeat (2) @(negedge GAME_clk);
        check_reset("reset");
        rst = 1'b0;
        model_step(0, 0, 0, 0, 16'd200);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0, 0, 0, 16'd200);
    endtask

    task automatic press_flap();
        repeat (2) tick(1, 0, 0, 0, 16'd200);
        idle(3);
    endtask

    task automatic restart_and_play();
        idle(62);
        press_flap();
        press_flap();
    endtask

    initial begin
        logic bf, bp;
        do_reset();
        idle(100);
        repeat (50) tick(1, 0, 0, 0, 16'd200);
        idle(5);
        repeat (5) begin tick(0, 0, 0, 1, 16'd200); tick(0, 0, 0, 0, 16'd200); end
        tick(0, 0, 1, 0, 16'd200);
        idle(8);
        press_flap();
        idle(60);
        press_flap();
        press_flap();
        repeat (3) begin tick(0, 0, 0, 1, 16'd200); idle(1); end
        tick(0, 0, 1, 0, 16'd200);
        restart_and_play();
        tick(0, 0, 0, 1, 16'd200);
        tick(0, 0, 1, 1, 16'd200);
        restart_and_play();
        tick(0, 0, 0, 1, 16'hFFFE);
        restart_and_play();
        repeat (5) tick(0, 0, 0, 0, 16'd459);
        tick(0, 0, 0, 0, 16'd460);
        restart_and_play();
        tick(0, 0, 0, 1, 16'd200);
        repeat (2) tick(0, 1, 0, 0, 16'd200);
        idle(3);
        for (int i = 0; i < 20; i++) tick(1'(i % 3 == 0), 0, 1, 1, 16'd470);
        idle(3);
        repeat (2) tick(1, 1, 0, 0, 16'd200);
        idle(4);
        repeat (1010) tick(0, 0, 0, 1, 16'd200);
        tick(0, 0, 1, 0, 16'd200);
        restart_and_play();
        repeat (7) begin tick(0, 0, 0, 1, 16'd300); idle(1); end
        @(posedge GAME_clk);
        #3;
        rst = 1'b1;
        drive(0, 0, 0, 0, 16'd200);
        #1;
        check_reset("async_rst");
        sb.delete();
        model_init();
        @(negedge GAME_clk);
        rst = 1'b0;
        model_step(0, 0, 0, 0, 16'd200);
        bf = 1'b0;
        bp = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) bf = ~bf;
            if ($urandom_range(0, 14) == 0) bp = ~bp;
            tick(bf, bp, 1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 99) == 0) ? 16'($urandom) : 16'($urandom_range(0, 470)));
        end
        idle(2);
        @(posedge GAME_clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
